arcade_input_cond: RTL and testbench

- Conditions raw AX309 board switches and keys into the Dig Dug core's INP0/INP1 input words, replacing the direct switch wiring in the top level.
- Per input: 2-FF synchroniser, then debouncer.
- Shapes each coin press into one fixed-width pulse.
- Drives the top level's reset-key request; that signal is consumed as resetKey, which is ORed into the hardware reset.

---
 rtl/arcade_input_cond.sv | 225 ++++++++++++++++++++++
 tb/tb_arcade_input_cond.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_cond.sv
// Conditions raw AX309 switches/keys into Dig Dug INP0/INP1: sync, debounce, coin shaping, reset-key hold.
// Build option: define AUTOFIRE_EN to make the pump bits auto-repeat while fire is held.
module arcade_input_cond #(
    parameter int unsigned TICK_DIV      = 49152,
    parameter int unsigned DEBOUNCE_MS   = 8,
    parameter int unsigned COIN_MS       = 100,
    parameter int unsigned RESET_HOLD_MS = 2000,
    parameter int unsigned AUTOFIRE_MS   = 60
) (
    input  logic       clk_48M,
    input  logic       nRESET,
    input  logic [4:0] sw_n,
    input  logic [3:0] key_n,
    output logic [7:0] inp0,
    output logic [7:0] inp1,
    output logic       reset_key
);

    localparam int unsigned N_IN   = 9;
    localparam int unsigned TICK_W = $clog2(TICK_DIV + 1);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned COIN_W = $clog2(COIN_MS + 1);
    localparam int unsigned HOLD_W = $clog2(RESET_HOLD_MS + 1);

    // Bit positions inside the combined {key_n, sw_n} input vector
    localparam int unsigned I_FIRE   = 0;
    localparam int unsigned I_COIN1  = 5;
    localparam int unsigned I_START1 = 6;
    localparam int unsigned I_START2 = 7;
    localparam int unsigned I_COIN2  = 8;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
    localparam logic [COIN_W-1:0] COIN_LOAD = COIN_W'(COIN_MS);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RESET_HOLD_MS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PULSE    = 2'd1,
        WAIT_REL = 2'd2
    } coin_state_e;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;

    logic [N_IN-1:0]   raw;
    logic [N_IN-1:0]   sync1;
    logic [N_IN-1:0]   sync2;
    logic [N_IN-1:0]   deb;
    logic [DB_W-1:0]   db_cnt [N_IN];

    coin_state_e       coin_state      [2];
    coin_state_e       coin_state_next [2];
    logic [COIN_W-1:0] coin_cnt        [2];
    logic [COIN_W-1:0] coin_cnt_next   [2];
    logic [1:0]        coin_deb;
    logic [1:0]        coin_out_c;

    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next_c;
    logic              reset_key_next_c;

    logic              pump_c;

    assign raw = {key_n, sw_n};

    // Free-running debounce tick prescaler
    assign tick_c = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_48M) begin
        if (!nRESET) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Two-stage synchroniser and per-input debouncer; a level must survive DEBOUNCE_MS ticks
    always_ff @(posedge clk_48M) begin
        if (!nRESET) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick_c) begin
                    if (db_cnt[i] == DB_LAST) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign coin_deb = {deb[I_COIN2], deb[I_COIN1]};

    // Coin shaper state registers
    always_ff @(posedge clk_48M) begin
        if (!nRESET) begin
            for (int c = 0; c < 2; c++) begin
                coin_state[c] <= IDLE;
                coin_cnt[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                coin_state[c] <= coin_state_next[c];
                coin_cnt[c]   <= coin_cnt_next[c];
            end
        end
    end

    // IDLE is only ever entered with the key released, so a low level there is a fresh press
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            coin_state_next[c] = coin_state[c];
            coin_cnt_next[c]   = coin_cnt[c];
            coin_out_c[c]      = 1'b1;
            case (coin_state[c])
                IDLE: begin
                    if (!coin_deb[c]) begin
                        coin_state_next[c] = PULSE;
                        coin_cnt_next[c]   = COIN_LOAD;
                        coin_out_c[c]      = 1'b0;
                    end
                end
                PULSE: begin
                    coin_out_c[c] = 1'b0;
                    if (coin_cnt[c] == '0) begin
                        coin_state_next[c] = WAIT_REL;
                        coin_out_c[c]      = 1'b1;
                    end else if (tick_c) begin
                        coin_cnt_next[c] = coin_cnt[c] - 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (coin_deb[c]) begin
                        coin_state_next[c] = IDLE;
                    end
                end
                default: begin
                    coin_state_next[c] = IDLE;
                end
            endcase
        end
    end

    // Start1+start2 hold timer; saturates, clears as soon as either key is released
    always_comb begin
        hold_next_c = hold_cnt;
        if (deb[I_START1] || deb[I_START2]) begin
            hold_next_c = '0;
        end else if (tick_c && (hold_cnt != HOLD_MAX)) begin
            hold_next_c = hold_cnt + 1'b1;
        end
    end

    assign reset_key_next_c = (hold_next_c == HOLD_MAX);

    always_ff @(posedge clk_48M) begin
        if (!nRESET) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_next_c;
        end
    end

`ifdef AUTOFIRE_EN
    localparam int unsigned AF_W = $clog2(AUTOFIRE_MS + 1);
    localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_MS - 1);

    logic [AF_W-1:0] af_cnt;
    logic            af_phase;

    // Autofire phase: starts low on the press, flips every AUTOFIRE_MS ticks while held
    always_ff @(posedge clk_48M) begin
        if (!nRESET || deb[I_FIRE]) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (tick_c) begin
            if (af_cnt == AF_LAST) begin
                af_cnt   <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_cnt <= af_cnt + 1'b1;
            end
        end
    end

    assign pump_c = deb[I_FIRE] | af_phase;
`else
    logic [31:0] af_unused;

    assign af_unused = 32'(AUTOFIRE_MS);
    assign pump_c    = deb[I_FIRE];
`endif

    // Output words; starts are masked while a reset request is being raised
    always_ff @(posedge clk_48M) begin
        if (!nRESET) begin
            inp0      <= 8'h3F;
            inp1      <= 8'hFF;
            reset_key <= 1'b0;
        end else begin
            inp0      <= {2'b00, coin_out_c[1], coin_out_c[0],
                          deb[I_START2] | reset_key_next_c,
                          deb[I_START1] | reset_key_next_c,
                          pump_c, pump_c};
            inp1      <= {deb[4:1], deb[4:1]};
            reset_key <= reset_key_next_c;
        end
    end

endmodule

// File: tb/tb_arcade_input_cond.sv
// Bench for arcade_input_cond: directed scenarios plus random stimulus against a tick-arithmetic reference model.
module tb_arcade_input_cond;

    localparam int TICK_DIV      = 4;
    localparam int DEBOUNCE_MS   = 3;
    localparam int COIN_MS       = 5;
    localparam int RESET_HOLD_MS = 10;
    localparam int AUTOFIRE_MS   = 2;

    logic       clk_48M = 1'b0;
    logic       nRESET  = 1'b0;
    logic [4:0] sw_n    = '1;
    logic [3:0] key_n   = '1;
    logic [7:0] inp0;
    logic [7:0] inp1;
    logic       reset_key;

    int n_checks = 0;
    int n_pass   = 0;

    arcade_input_cond #(
        .TICK_DIV     (TICK_DIV),
        .DEBOUNCE_MS  (DEBOUNCE_MS),
        .COIN_MS      (COIN_MS),
        .RESET_HOLD_MS(RESET_HOLD_MS),
        .AUTOFIRE_MS  (AUTOFIRE_MS)
    ) dut (
        .clk_48M  (clk_48M),
        .nRESET   (nRESET),
        .sw_n     (sw_n),
        .key_n    (key_n),
        .inp0     (inp0),
        .inp1     (inp1),
        .reset_key(reset_key)
    );

    always #5 clk_48M = ~clk_48M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_48M);
        #1;
    endtask

    // Number of tick edges k in [a,b], where edge k (counted from reset release) ticks when k%TICK_DIV==TICK_DIV-1
    function automatic int ticks_in(input int a, input int b);
        if (b < a) return 0;
        return (b + 1) / TICK_DIV - a / TICK_DIV;
    endfunction

    // ---------------- reference model ----------------
    int          m_k;
    logic [8:0]  m_q[$];
    logic [8:0]  m_deb;
    int          m_nd[9];
    int          m_cph[2];
    int          m_cstart[2];
    bit          m_both;
    int          m_both_since;
    bit          m_fire_on;
    int          m_fire_since;
    logic [7:0]  exp_inp0;
    logic [7:0]  exp_inp1;
    logic        exp_rk;
    bit          model_ok = 0;

    always @(posedge clk_48M) begin
        logic [8:0] samp;
        logic [8:0] pre;
        logic [1:0] coin_hi;
        logic       rk;
        logic       pump;
        bit         tick;
        if (!nRESET) begin
            m_k = 0;
            m_q.delete();
            m_q.push_back('1);
            m_q.push_back('1);
            m_deb = '1;
            for (int i = 0; i < 9; i++) m_nd[i] = 0;
            m_cph[0] = 0;
            m_cph[1] = 0;
            m_both = 0;
            m_fire_on = 0;
            exp_inp0 = 8'h3F;
            exp_inp1 = 8'hFF;
            exp_rk = 1'b0;
            model_ok = 1;
        end else begin
            tick = (m_k % TICK_DIV) == TICK_DIV - 1;
            samp = m_q.pop_front();
            m_q.push_back({key_n, sw_n});
            pre = m_deb;
            // coin: one pulse per press, lasting COIN_MS ticks counted after the start edge
            for (int c = 0; c < 2; c++) begin
                int idx;
                idx = (c == 0) ? 5 : 8;
                case (m_cph[c])
                    0: if (!pre[idx]) begin m_cph[c] = 1; m_cstart[c] = m_k; end
                    1: if (ticks_in(m_cstart[c] + 1, m_k - 1) >= COIN_MS) m_cph[c] = 2;
                    default: if (pre[idx]) m_cph[c] = 0;
                endcase
                coin_hi[c] = (m_cph[c] != 1);
            end
            // reset key: ticks elapsed with both starts held, capped
            if (pre[6] || pre[7]) m_both = 0;
            else if (!m_both) begin m_both = 1; m_both_since = m_k; end
            rk = m_both && (ticks_in(m_both_since, m_k) >= RESET_HOLD_MS);
`ifdef AUTOFIRE_EN
            if (pre[0]) begin
                m_fire_on = 0;
                pump = 1'b1;
            end else begin
                if (!m_fire_on) begin m_fire_on = 1; m_fire_since = m_k; end
                pump = ((ticks_in(m_fire_since, m_k - 1) / AUTOFIRE_MS) % 2) == 1;
            end
`else
            pump = pre[0];
`endif
            exp_inp0 = {2'b00, coin_hi[1], coin_hi[0], pre[7] | rk, pre[6] | rk, pump, pump};
            exp_inp1 = {pre[4:1], pre[4:1]};
            exp_rk   = rk;
            // debounce: accept a level after DEBOUNCE_MS ticks of continuous disagreement
            for (int i = 0; i < 9; i++) begin
                if (samp[i] == m_deb[i]) m_nd[i] = 0;
                else if (tick) begin
                    m_nd[i]++;
                    if (m_nd[i] == DEBOUNCE_MS) begin
                        m_deb[i] = samp[i];
                        m_nd[i] = 0;
                    end
                end
            end
            m_k++;
        end
    end

    always @(negedge clk_48M) begin
        if (model_ok) begin
            check("inp0", 32'(inp0), 32'(exp_inp0));
            check("inp1", 32'(inp1), 32'(exp_inp1));
            check("reset_key", 32'(reset_key), 32'(exp_rk));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic measure_coin(input int cycles, output int width, output int pulses);
        logic prev;
        prev = 1'b1;
        width = 0;
        pulses = 0;
        repeat (cycles) begin
            step(1);
            if (!inp0[4]) width++;
            if (prev && !inp0[4]) pulses++;
            prev = inp0[4];
        end
    endtask

    initial begin
        int n;
        int w;
        int p;
        logic [7:0] g;
        logic [1:0] v;

        // reset
        nRESET = 1'b0;
        step(2);
        check("rst_inp0", 32'(inp0), 32'h3F);
        check("rst_inp1", 32'(inp1), 32'hFF);
        check("rst_rk", 32'(reset_key), 32'h0);
        nRESET = 1'b1;
        step(5);
        check("post_rst_inp0", 32'(inp0), 32'h3F);
        check("post_rst_inp1", 32'(inp1), 32'hFF);

        // glitch rejection
        sw_n[1] = 1'b0;
        step(6);
        sw_n[1] = 1'b1;
        g = 8'hFF;
        repeat (30) begin
            step(1);
            if (inp1 != 8'hFF) g = inp1;
        end
        check("glitch_inp1", 32'(g), 32'hFF);

        // held up-switch: bounded latency
        sw_n[1] = 1'b0;
        n = 0;
        do begin step(1); n++; end while (inp1 != 8'hEE && n < 40);
        check("up_inp1", 32'(inp1), 32'hEE);
        check("up_latency_ok", 32'(n >= 11 && n <= 15), 32'h1);
        sw_n[1] = 1'b1;
        step(30);
        check("up_release", 32'(inp1), 32'hFF);

        // coin: one pulse per press
        key_n[0] = 1'b0;
        measure_coin(200, w, p);
        check("coin_width", 32'(w), 32'd20);
        check("coin_pulses", 32'(p), 32'd1);
        key_n[0] = 1'b1;
        step(30);
        key_n[0] = 1'b0;
        measure_coin(60, w, p);
        check("coin2nd_width", 32'(w), 32'd20);
        check("coin2nd_pulses", 32'(p), 32'd1);
        key_n[0] = 1'b1;
        step(30);

        // reset key
        key_n[1] = 1'b0;
        key_n[2] = 1'b0;
        n = 0;
        do begin step(1); n++; end while (inp0[3:2] != 2'b00 && n < 40);
        check("starts_low", 32'(inp0[3:2]), 32'h0);
        n = 0;
        while (!reset_key && n < 100) begin step(1); n++; end
        check("rk_delay", 32'(n), 32'd39);
        repeat (5) begin
            check("rk_mask_starts", 32'(inp0[3:2]), 32'h3);
            step(1);
        end
        check("rk_saturated", 32'(reset_key), 32'h1);
        key_n[2] = 1'b1;
        n = 0;
        while (reset_key && n < 30) begin step(1); n++; end
        check("rk_dropped", 32'(reset_key), 32'h0);
        check("rk_starts_after", 32'(inp0[3:2]), 32'h2);
        key_n[1] = 1'b1;
        step(30);

        // reset during a coin pulse
        key_n[3] = 1'b0;
        n = 0;
        do begin step(1); n++; end while (inp0[5] && n < 40);
        check("coin2_started", 32'(inp0[5]), 32'h0);
        step(5);
        nRESET = 1'b0;
        step(1);
        check("midrst_inp0", 32'(inp0), 32'h3F);
        nRESET = 1'b1;
        measure_coin(1, w, p);
        n = 0;
        w = 0;
        do begin step(1); n++; end while (inp0[5] && n < 40);
        while (!inp0[5] && w < 40) begin step(1); w++; end
        check("midrst_repulse_width", 32'(w), 32'd20);
        key_n[3] = 1'b1;
        step(30);

        // fire / autofire
        sw_n[0] = 1'b0;
        n = 0;
        do begin step(1); n++; end while (inp0[1:0] == 2'b11 && n < 40);
        check("fire_low", 32'(inp0[1:0]), 32'h0);
`ifdef AUTOFIRE_EN
        for (int r = 0; r < 4; r++) begin
            v = inp0[1:0];
            check("af_level", 32'(v), (r % 2 == 0) ? 32'h0 : 32'h3);
            n = 0;
            do begin step(1); n++; end while (inp0[1:0] == v && n < 30);
            check("af_run", 32'(n), 32'd8);
        end
`else
        step(40);
        check("fire_steady", 32'(inp0[1:0]), 32'h0);
`endif
        sw_n[0] = 1'b1;
        n = 0;
        while (inp0[1:0] != 2'b11 && n < 30) begin step(1); n++; end
        check("fire_release", 32'(inp0[1:0]), 32'h3);
        step(10);

        // random stimulus against the model
        for (int s = 0; s < 160; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                nRESET = 1'b0;
                step($urandom_range(1, 2));
                nRESET = 1'b1;
            end
            for (int b = 0; b < 5; b++) sw_n[b] = ($urandom_range(0, 9) < 3) ? 1'b0 : 1'b1;
            for (int b = 0; b < 4; b++) key_n[b] = ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1;
            if (s % 10 == 0) step($urandom_range(60, 150));
            else step($urandom_range(1, 40));
        end
        sw_n = '1;
        key_n = '1;
        step(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
